// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain with bubble collapsing, a global hold,
// per-stage flush and a live-word occupancy count.
module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  input  logic              i_hold,
  input  logic [DEPTH-1:0]  i_flush,
  output logic [OCC_W-1:0]  o_occupancy
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic [DEPTH-1:0]  live;
  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  ld;
  logic [DEPTH-1:0]  in_valid;
  logic [DATA_W-1:0] in_data [DEPTH];
  logic [OCC_W-1:0]  occ;

  // A stage advances when the output drains or any slot above it is free,
  // which is the unrolled form of the output-to-input ready recursion.
  always_comb begin : advanceLogic
    logic gap;
    live = valid_q & ~i_flush;
    adv  = '0;
    gap  = i_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = ~i_hold & gap;
      gap    = gap | ~live[k];
    end
    ld = {DEPTH{~i_hold}} & (~live | adv);
  end

  always_comb begin : nextState
    in_valid    = '0;
    in_valid[0] = i_valid;
    in_data[0]  = i_data;
    for (int k = 1; k < DEPTH; k++) begin
      in_valid[k] = live[k-1];
      in_data[k]  = data_q[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = ld[k] ? in_valid[k] : live[k];
      data_d[k]  = (ld[k] && in_valid[k]) ? in_data[k] : data_q[k];
    end
  end

  always_comb begin : occupancyCount
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(live[k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Reset forces the upstream handshake closed even though the chain is empty.
  assign o_ready     = rst & ld[0];
  assign o_valid     = live[DEPTH-1];
  assign o_data      = data_q[DEPTH-1];
  assign o_occupancy = occ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios plus random
// traffic, all compared against a slot-level behavioural model.
module tb_pipe_stage_chain;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int OCCW  = $clog2(DEPTH + 1);

  logic            clk;
  logic            rst;
  logic            i_valid;
  logic [DW-1:0]   i_data;
  logic            o_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic            i_ready;
  logic            i_hold;
  logic [DEPTH-1:0] i_flush;
  logic [OCCW-1:0] o_occupancy;

  int checkCount = 0;
  int errorCount = 0;

  bit            mv [DEPTH];
  logic [DW-1:0] md [DEPTH];

  pipe_stage_chain #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready), .i_hold(i_hold), .i_flush(i_flush),
    .o_occupancy(o_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelClear();
    for (int k = 0; k < DEPTH; k++) begin
      mv[k] = 0;
      md[k] = '0;
    end
  endtask

  // One cycle: drive inputs at the falling edge, compare the combinational
  // outputs against the model, then let the model take the rising edge.
  task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit rdy,
                               input bit hold, input logic [DEPTH-1:0] flush);
    bit            lv [DEPTH];
    bit            nv [DEPTH];
    logic [DW-1:0] nd [DEPTH];
    bit            full;
    bit            expReady;
    bit            space;
    int            expOcc;
    i_valid = v;
    i_data  = d;
    i_ready = rdy;
    i_hold  = hold;
    i_flush = flush;
    #1;
    full   = 1;
    expOcc = 0;
    for (int k = 0; k < DEPTH; k++) begin
      lv[k] = mv[k] && !flush[k];
      if (lv[k]) expOcc++;
      else full = 0;
    end
    // The chain takes a word unless held, or full with nothing leaving.
    expReady = !hold && (rdy || !full);
    checkOutput("o_ready", {31'b0, o_ready}, {31'b0, expReady});
    checkOutput("o_valid", {31'b0, o_valid}, {31'b0, lv[DEPTH-1]});
    checkOutput("o_occupancy", DW'(o_occupancy), DW'(expOcc));
    if (lv[DEPTH-1]) checkOutput("o_data", o_data, md[DEPTH-1]);
    @(posedge clk);
    for (int k = 0; k < DEPTH; k++) begin
      nv[k] = 0;
      nd[k] = md[k];
    end
    if (hold) begin
      for (int k = 0; k < DEPTH; k++) nv[k] = lv[k];
    end else begin
      if (lv[DEPTH-1] && !rdy) nv[DEPTH-1] = 1;
      for (int k = DEPTH - 2; k >= 0; k--) begin
        if (lv[k]) begin
          space = rdy;
          for (int j = k + 1; j < DEPTH; j++) if (!lv[j]) space = 1;
          if (space) begin
            nv[k+1] = 1;
            nd[k+1] = md[k];
          end else begin
            nv[k] = 1;
          end
        end
      end
      if (expReady && v) begin
        nv[0] = 1;
        nd[0] = d;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      mv[k] = nv[k];
      md[k] = nd[k];
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, '0, 1, 0, '0);
  endtask

  initial begin
    int cyc;
    rst     = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
    i_hold  = 1'b0;
    i_flush = '0;
    modelClear();
    #1;
    checkOutput("reset_o_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("reset_o_data", o_data, 32'd0);
    checkOutput("reset_o_occupancy", DW'(o_occupancy), 32'd0);
    checkOutput("reset_o_ready", {31'b0, o_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] fill with consecutive pushes");
    applyStimulus(1, 32'h11, 1, 0, '0);
    applyStimulus(1, 32'h22, 1, 0, '0);
    applyStimulus(1, 32'h33, 1, 0, '0);
    applyStimulus(1, 32'h44, 1, 0, '0);
    checkOutput("fill_head", o_data, 32'h11);
    checkOutput("fill_peak_occ", DW'(o_occupancy), 32'd4);
    drain();

    $display("[TB] back-pressure and simultaneous push/pop");
    applyStimulus(1, 32'h11, 0, 0, '0);
    applyStimulus(1, 32'h22, 0, 0, '0);
    applyStimulus(1, 32'h33, 0, 0, '0);
    applyStimulus(1, 32'h44, 0, 0, '0);
    checkOutput("full_o_ready", {31'b0, o_ready}, 32'd0);
    checkOutput("full_occ", DW'(o_occupancy), 32'd4);
    applyStimulus(1, 32'h55, 1, 0, '0);
    i_ready = 1'b0;
    #1;
    checkOutput("pushpop_head", o_data, 32'h22);
    checkOutput("pushpop_occ", DW'(o_occupancy), 32'd4);
    drain();

    $display("[TB] bubble collapse");
    applyStimulus(1, 32'hA1, 0, 0, '0);
    applyStimulus(0, '0, 0, 0, '0);
    applyStimulus(0, '0, 0, 0, '0);
    applyStimulus(1, 32'hA2, 0, 0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, 0, '0);
    checkOutput("bubble_occ", DW'(o_occupancy), 32'd2);
    checkOutput("bubble_head", o_data, 32'hA1);
    applyStimulus(0, '0, 1, 0, '0);
    checkOutput("bubble_next", o_data, 32'hA2);
    drain();

    $display("[TB] flush of inner stages");
    for (int i = 1; i <= 4; i++) applyStimulus(1, DW'(i), 0, 0, '0);
    applyStimulus(0, '0, 0, 0, 4'b0110);
    drain();

    $display("[TB] hold with concurrent flush");
    for (int i = 1; i <= 3; i++) applyStimulus(1, DW'(32'hB0 + i), 0, 0, '0);
    applyStimulus(0, '0, 0, 0, '0);
    applyStimulus(1, 32'hC1, 1, 1, 4'b1000);
    applyStimulus(1, 32'hC2, 1, 1, '0);
    applyStimulus(1, 32'hC3, 1, 1, '0);
    checkOutput("hold_o_ready", {31'b0, o_ready}, 32'd0);
    drain();

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 1; i <= 3; i++) applyStimulus(1, DW'(32'hD0 + i), 0, 0, '0);
    i_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midreset_o_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("midreset_o_data", o_data, 32'd0);
    checkOutput("midreset_occ", DW'(o_occupancy), 32'd0);
    checkOutput("midreset_o_ready", {31'b0, o_ready}, 32'd0);
    modelClear();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1, 32'hE1, 1, 0, '0);
    cyc = 1;
    while (!o_valid && cyc < 20) begin
      applyStimulus(0, '0, 1, 0, '0);
      cyc++;
    end
    checkOutput("latency", DW'(cyc), DW'(DEPTH));
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 7) == 0,
                    ($urandom_range(0, 5) == 0) ? DEPTH'($urandom) : '0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised elastic pipeline register chain that replaces the fixed single-stage latches between pipeline stages of the MIPS core. It holds up to DEPTH in-flight words, each with its own valid bit. Data moves under a valid/ready handshake with bubble collapsing. The block adds a global hold (the `i_stall` equivalent), a per-stage flush vector and an occupancy count, none of which the plain latch provides.

## Interface
- `DATA_W`, default 32: width of each stage's payload (instruction, control bundle, etc.).
- `DEPTH`, default 4: number of register stages, ≥1. Stage 0 is the input side; stage DEPTH-1 drives the outputs.
- `OCC_W`, default $clog2(DEPTH+1): width of the occupancy count.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: upstream word present on `i_data`.
- `i_data` in DATA_W: upstream payload.
- `o_ready` out 1: chain accepts `i_data` this cycle.
- `o_valid` out 1: stage DEPTH-1 holds a live word.
- `o_data` out DATA_W: payload of stage DEPTH-1.
- `i_ready` in 1: downstream consumes `o_data` this cycle.
- `i_hold` in 1: global stall; freezes all movement.
- `i_flush` in DEPTH: bit k kills the word in stage k at the next edge.
- `o_occupancy` out OCC_W: number of live stages, excluding words being flushed this cycle.

## Operation
- State per stage k: `v[k]` and `d[k]` (DATA_W).
- Live condition: `live[k] = v[k] & ~i_flush[k]`.
- Output stage advance: `adv[DEPTH-1] = ~i_hold & i_ready`.
- Inner stage advance: `adv[k] = ~i_hold & (~live[k+1] | adv[k+1])`, evaluated combinationally from the output end. This is bubble collapsing: an empty or flushed slot absorbs upstream data in the same cycle.
- `o_ready = ~i_hold & (~live[0] | adv[0])`.
- Stage k load enable: `ld[k] = ~i_hold & (~live[k] | adv[k])`.
- On load, `v[k] <= live[k-1]` (for stage 0, `i_valid`). `d[k]` is written only when the incoming valid is 1. If the incoming valid is 0, `d[k]` holds its value and is don't-care.
- When stage k does not load, `v[k] <= live[k]` and `d[k]` holds. A flushed stage therefore clears even under `i_hold`.
- Flushed words never propagate: `live` masks them on the shift path.
- Outputs: `o_valid = live[DEPTH-1]`, `o_data = d[DEPTH-1]`. A word is consumed when `o_valid & i_ready & ~i_hold`.
- `o_occupancy` is the popcount of `live[DEPTH-1:0]`, combinational.
- DEPTH=1 degenerates to a single registered slot with the same rules.

## Timing
- Reset (rst=0, asynchronous) sets all `v` to 0 and all `d` to 0. While rst=0: `o_valid`=0, `o_data`=0, `o_occupancy`=0 and `o_ready` is forced to 0.
- The first edge after reset release with `i_valid`=1 and `i_hold`=0 accepts a word.
- Latency is DEPTH cycles from acceptance to `o_valid`=1 when there is no hold and no back-pressure.
- Throughput is 1 word/cycle when `i_ready`=1.
- Full chain (all stages live) with `i_ready`=0: `o_ready`=0.
- Full chain with `i_ready`=1: `o_ready`=1 and a simultaneous push and pop is accepted.
- Empty chain: `o_ready`=~`i_hold`. `i_ready` is ignored when `o_valid`=0.
- `i_hold`=1 overrides `i_ready` and `i_valid`: no word enters, moves or leaves. `i_flush` still clears its stages.
- A flush and an upstream arrival into the same stage in the same cycle: the arriving word is kept and the old word is killed.
- Flushing stage DEPTH-1 while `i_ready`=1: `o_valid` is already 0 that cycle, so no consumption is counted.
- Reset asserted mid-stream drops all in-flight words immediately. No handshake is completed on that cycle.
- All paths `i_ready`/`i_flush` → `o_ready` are combinational.
- No combinational path exists from `i_valid`/`i_data` to any output.

## Test plan
- Reset and fill (DEPTH=4, DATA_W=32). Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `i_ready`=1. Required: `o_valid` rises 4 cycles after the first push, `o_data` reads 0x11..0x44 on consecutive cycles, `o_occupancy` peaks at 4.
- Back-pressure and simultaneous push/pop. Fill 4 words with `i_ready`=0. Required: `o_ready`=0, occupancy 4. Then raise `i_ready` and `i_valid` with 0x55. Required: pop 0x11 and accept 0x55 on the same edge, occupancy stays 4.
- Bubble collapse. Push 0xA1, idle 2 cycles, push 0xA2, hold `i_ready`=0. Required: after 5 cycles stages 3 and 2 hold 0xA1 and 0xA2 with no gap, occupancy 2.
- Flush. Chain holds 0x01..0x04. Pulse `i_flush`=4'b0110. Required: `o_occupancy` drops to 2 in the same cycle, and the output sequence is 0x01 then 0x04 only.
- Hold. Chain holds 3 words, `i_hold`=1 for 3 cycles with `i_valid`=1 and `i_ready`=1. Required: no state change, `o_ready`=0. A concurrent `i_flush[3]` still clears stage 3.
- Asynchronous reset mid-stream. Drive rst=0 between edges with 3 words in flight. Required: `o_valid`, `o_data` and `o_occupancy` go to 0 immediately. After release, the first pushed word emerges after exactly DEPTH cycles.
